// File: rtl/unified_mem_arbiter_if.sv
// Request, response and memory-side signals of the unified memory arbiter.
// slave: arbiter view; master: requester/memory environment view.
interface unified_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_stall;
    logic        dm_read;
    logic        dm_write;
    logic [2:0]  dm_funct3;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_misalign;
    logic        dm_stall;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] perf_if_stalls;
    logic [15:0] perf_dm_stalls;

    modport slave (
        input  if_req, if_addr, dm_read, dm_write, dm_funct3, dm_addr, dm_wdata, mem_rdata,
        output if_inst, if_valid, if_stall, dm_rdata, dm_valid, dm_misalign, dm_stall,
        output mem_read, mem_write, mem_funct3, mem_addr, mem_wdata,
        output perf_if_stalls, perf_dm_stalls
    );

    modport master (
        output if_req, if_addr, dm_read, dm_write, dm_funct3, dm_addr, dm_wdata, mem_rdata,
        input  if_inst, if_valid, if_stall, dm_rdata, dm_valid, dm_misalign, dm_stall,
        input  mem_read, mem_write, mem_funct3, mem_addr, mem_wdata,
        input  perf_if_stalls, perf_dm_stalls
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Per-cycle arbiter between instruction fetch and load/store for a single-ported memory.
// Optional stall counters are enabled by defining ARB_PERF_CNT_EN.
module unified_mem_arbiter #(
    parameter int unsigned INST_BASE  = 128,
    parameter int unsigned ADDR_BITS  = 9,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StGntIf, StGntDm} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e                 state_q, state_d;
    logic [3:0]             starve_q, starve_d;
    logic [31:0]            if_inst_q, dm_rdata_q;
    logic                   misalign_q;
    logic                   dm_req, is_store, dm_bad;
    logic                   gnt_if, gnt_dm;
    logic [ADDR_BITS-1:0]   fetch_addr;

    assign dm_req     = bus.dm_read | bus.dm_write;
    assign is_store   = bus.dm_write;
    assign gnt_dm     = dm_req & ~(bus.if_req & (starve_q == StarveMax));
    assign gnt_if     = bus.if_req & ~gnt_dm;
    assign fetch_addr = bus.if_addr[ADDR_BITS-1:0] + ADDR_BITS'(INST_BASE);

    always_comb begin
        dm_bad = 1'b0;
        case (bus.dm_funct3)
            3'b000:  dm_bad = 1'b0;
            3'b001:  dm_bad = bus.dm_addr[0];
            3'b010:  dm_bad = |bus.dm_addr[1:0];
            3'b100:  dm_bad = is_store;
            3'b101:  dm_bad = is_store | bus.dm_addr[0];
            default: dm_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = gnt_if ? StGntIf : (gnt_dm ? StGntDm : StIdle);
        starve_d = starve_q;
        if (!bus.if_req || gnt_if) begin
            starve_d = 4'd0;
        end else if (gnt_dm && starve_q != StarveMax) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_comb begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_funct3 = 3'b000;
        bus.mem_addr   = 32'd0;
        bus.mem_wdata  = 32'd0;
        if (gnt_if) begin
            bus.mem_read   = 1'b1;
            bus.mem_funct3 = 3'b010;
            bus.mem_addr   = 32'(fetch_addr);
        end else if (gnt_dm) begin
            bus.mem_funct3 = bus.dm_funct3;
            bus.mem_addr   = 32'(bus.dm_addr[ADDR_BITS-1:0]);
            bus.mem_wdata  = bus.dm_wdata;
            if (!dm_bad) begin
                bus.mem_write = is_store;
                bus.mem_read  = ~is_store;
            end
        end
        // Memory strobes must die the instant reset asserts, even mid-cycle.
        if (!rst) begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            starve_q   <= 4'd0;
            if_inst_q  <= 32'd0;
            dm_rdata_q <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            misalign_q <= gnt_dm & dm_bad;
            if (gnt_if) begin
                if_inst_q <= bus.mem_rdata;
            end
            if (gnt_dm) begin
                if (dm_bad) begin
                    dm_rdata_q <= 32'd0;
                end else if (!is_store) begin
                    dm_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    // The state holds last cycle's grant, so it directly forms the completion pulses.
    assign bus.if_valid    = (state_q == StGntIf);
    assign bus.dm_valid    = (state_q == StGntDm);
    assign bus.if_inst     = if_inst_q;
    assign bus.dm_rdata    = dm_rdata_q;
    assign bus.dm_misalign = misalign_q;
    assign bus.if_stall    = bus.if_req & ~gnt_if;
    assign bus.dm_stall    = dm_req & ~gnt_dm;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_if_q, perf_dm_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_q <= 16'd0;
            perf_dm_q <= 16'd0;
        end else begin
            if (bus.if_stall && perf_if_q != 16'hFFFF) begin
                perf_if_q <= perf_if_q + 16'd1;
            end
            if (bus.dm_stall && perf_dm_q != 16'hFFFF) begin
                perf_dm_q <= perf_dm_q + 16'd1;
            end
        end
    end

    assign bus.perf_if_stalls = perf_if_q;
    assign bus.perf_dm_stalls = perf_dm_q;
`else
    assign bus.perf_if_stalls = 16'd0;
    assign bus.perf_dm_stalls = 16'd0;
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter with a byte-addressed memory model.
module tb_unified_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mem_loaded = 1'b0;
    logic [7:0] mem [512];

    unified_mem_arbiter_if bus ();

    unified_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read with load extension, write at posedge.
    always_comb begin
        logic [8:0] a;
        a = bus.mem_addr[8:0];
        bus.mem_rdata = 32'd0;
        case (bus.mem_funct3)
            3'b000: bus.mem_rdata = {{24{mem[a][7]}}, mem[a]};
            3'b001: bus.mem_rdata = {{16{mem[a+9'd1][7]}}, mem[a+9'd1], mem[a]};
            3'b010: bus.mem_rdata = {mem[a+9'd3], mem[a+9'd2], mem[a+9'd1], mem[a]};
            3'b100: bus.mem_rdata = {24'd0, mem[a]};
            3'b101: bus.mem_rdata = {16'd0, mem[a+9'd1], mem[a]};
            default: bus.mem_rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            mem[128] <= 8'h93;
            mem[129] <= 8'h04;
            mem[130] <= 8'h10;
            mem[131] <= 8'h00;
            mem_loaded <= 1'b1;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[8:0]] <= bus.mem_wdata[7:0];
            if (bus.mem_funct3[1:0] != 2'b00) begin
                mem[bus.mem_addr[8:0] + 9'd1] <= bus.mem_wdata[15:8];
            end
            if (bus.mem_funct3[1:0] == 2'b10) begin
                mem[bus.mem_addr[8:0] + 9'd2] <= bus.mem_wdata[23:16];
                mem[bus.mem_addr[8:0] + 9'd3] <= bus.mem_wdata[31:24];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dm(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bus.dm_read   = rd;
        bus.dm_write  = wr;
        bus.dm_funct3 = f3;
        bus.dm_addr   = addr;
        bus.dm_wdata  = wdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_if;
        logic [15:0] exp_pif, exp_pdm;
`ifdef ARB_PERF_CNT_EN
        exp_pif = 16'd8;
        exp_pdm = 16'd2;
`else
        exp_pif = 16'd0;
        exp_pdm = 16'd0;
`endif
        bus.if_req  = 1'b1;
        bus.if_addr = 32'd0;
        set_dm(1'b0, 1'b1, 3'b010, 32'h10, 32'h1);

        // Reset state, with requests present
        #2;
        check_eq("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check_eq("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check_eq("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check_eq("rst_dm_valid", 32'(bus.dm_valid), 32'd0);
        check_eq("rst_misalign", 32'(bus.dm_misalign), 32'd0);
        check_eq("rst_if_inst", bus.if_inst, 32'd0);
        check_eq("rst_dm_rdata", bus.dm_rdata, 32'd0);
        tick();
        tick();
        bus.if_req = 1'b0;
        set_dm(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        rst = 1'b1;

        // Instruction fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'd0;
        #1;
        check_eq("fetch_mem_addr", bus.mem_addr, 32'h80);
        check_eq("fetch_mem_read", 32'(bus.mem_read), 32'd1);
        check_eq("fetch_mem_funct3", 32'(bus.mem_funct3), 32'd2);
        check_eq("fetch_if_stall", 32'(bus.if_stall), 32'd0);
        tick();
        bus.if_req = 1'b0;
        check_eq("fetch_if_inst", bus.if_inst, 32'h00100493);
        check_eq("fetch_if_valid", 32'(bus.if_valid), 32'd1);
        check_eq("fetch_dm_valid", 32'(bus.dm_valid), 32'd0);
        tick();
        check_eq("fetch_valid_drop", 32'(bus.if_valid), 32'd0);
        check_eq("fetch_inst_hold", bus.if_inst, 32'h00100493);

        // Fetch address wrap
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h180;
        #1;
        check_eq("wrap_mem_addr", bus.mem_addr, 32'h0);
        tick();
        bus.if_req = 1'b0;
        check_eq("wrap_if_inst", bus.if_inst, 32'h0);

        // Store then signed/unsigned byte loads
        set_dm(1'b0, 1'b1, 3'b010, 32'h14, 32'hDEADBEEF);
        #1;
        check_eq("sw_mem_write", 32'(bus.mem_write), 32'd1);
        check_eq("sw_mem_read", 32'(bus.mem_read), 32'd0);
        check_eq("sw_mem_addr", bus.mem_addr, 32'h14);
        check_eq("sw_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        check_eq("sw_dm_stall", 32'(bus.dm_stall), 32'd0);
        tick();
        set_dm(1'b1, 1'b0, 3'b000, 32'h17, 32'd0);
        check_eq("sw_dm_valid", 32'(bus.dm_valid), 32'd1);
        check_eq("sw_misalign", 32'(bus.dm_misalign), 32'd0);
        check_eq("sw_byte17", 32'(mem[9'h17]), 32'hDE);
        #1;
        check_eq("lb_mem_read", 32'(bus.mem_read), 32'd1);
        tick();
        set_dm(1'b1, 1'b0, 3'b100, 32'h17, 32'd0);
        check_eq("lb_rdata", bus.dm_rdata, 32'hFFFFFFDE);
        check_eq("lb_dm_valid", 32'(bus.dm_valid), 32'd1);
        tick();
        set_dm(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        check_eq("lbu_rdata", bus.dm_rdata, 32'h000000DE);

        // Misaligned and illegal accesses
        set_dm(1'b1, 1'b0, 3'b010, 32'h06, 32'd0);
        #1;
        check_eq("mis_lw_mem_read", 32'(bus.mem_read), 32'd0);
        check_eq("mis_lw_dm_stall", 32'(bus.dm_stall), 32'd0);
        tick();
        set_dm(1'b0, 1'b1, 3'b001, 32'h03, 32'h1234);
        check_eq("mis_lw_valid", 32'(bus.dm_valid), 32'd1);
        check_eq("mis_lw_misalign", 32'(bus.dm_misalign), 32'd1);
        check_eq("mis_lw_rdata", bus.dm_rdata, 32'd0);
        #1;
        check_eq("mis_sh_mem_write", 32'(bus.mem_write), 32'd0);
        tick();
        set_dm(1'b0, 1'b1, 3'b100, 32'h10, 32'h55);
        check_eq("mis_sh_misalign", 32'(bus.dm_misalign), 32'd1);
        check_eq("mis_sh_bytes", 32'({mem[9'h4], mem[9'h3]}), 32'd0);
        tick();
        set_dm(1'b1, 1'b0, 3'b011, 32'h20, 32'd0);
        check_eq("ill_sbu_misalign", 32'(bus.dm_misalign), 32'd1);
        tick();
        set_dm(1'b1, 1'b0, 3'b010, 32'h14, 32'd0);
        check_eq("ill_f3_misalign", 32'(bus.dm_misalign), 32'd1);
        check_eq("ill_sbu_byte10", 32'(mem[9'h10]), 32'd0);
        tick();
        set_dm(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        check_eq("lw_rdata", bus.dm_rdata, 32'hDEADBEEF);
        check_eq("lw_misalign", 32'(bus.dm_misalign), 32'd0);
        tick();

        // Reset asserted mid-store
        bus.if_req  = 1'b1;
        bus.if_addr = 32'd0;
        tick();
        bus.if_req = 1'b0;
        check_eq("pre_rst_if_inst", bus.if_inst, 32'h00100493);
        set_dm(1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D);
        #1;
        check_eq("pre_rst_mem_write", 32'(bus.mem_write), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("mid_rst_mem_write", 32'(bus.mem_write), 32'd0);
        check_eq("mid_rst_if_inst", bus.if_inst, 32'd0);
        check_eq("mid_rst_dm_rdata", bus.dm_rdata, 32'd0);
        check_eq("mid_rst_if_valid", 32'(bus.if_valid), 32'd0);
        tick();
        check_eq("mid_rst_byte20", 32'({mem[9'h23], mem[9'h22], mem[9'h21], mem[9'h20]}), 32'd0);
        set_dm(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        tick();
        rst = 1'b1;
        check_eq("post_rst_dm_valid", 32'(bus.dm_valid), 32'd0);
        check_eq("post_rst_if_valid", 32'(bus.if_valid), 32'd0);

        // Starvation: continuous store plus fetch request
        set_dm(1'b0, 1'b1, 3'b010, 32'h40, 32'h11111111);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'd0;
        for (int k = 0; k < 10; k++) begin
            exp_if = ((k % 5) == 4);
            #1;
            check_eq($sformatf("starve_if_stall_%0d", k), 32'(bus.if_stall), 32'(!exp_if));
            check_eq($sformatf("starve_dm_stall_%0d", k), 32'(bus.dm_stall), 32'(exp_if));
            check_eq($sformatf("starve_mem_addr_%0d", k), bus.mem_addr, exp_if ? 32'h80 : 32'h40);
            tick();
            check_eq($sformatf("starve_if_valid_%0d", k), 32'(bus.if_valid), 32'(exp_if));
            check_eq($sformatf("starve_dm_valid_%0d", k), 32'(bus.dm_valid), 32'(!exp_if));
        end
        bus.if_req = 1'b0;
        set_dm(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        #1;
        check_eq("perf_if_stalls", 32'(bus.perf_if_stalls), 32'(exp_pif));
        check_eq("perf_dm_stalls", 32'(bus.perf_dm_stalls), 32'(exp_pdm));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
